// File: rtl/dec_round_key_gen_pkg.sv
// Shared types, per-mode key-schedule constants and GF(2^8) helpers for dec_round_key_gen.
// InvMixColumns helper exists only when DEC_EQ_INV_KEY_EN is defined.
package dec_round_key_gen_pkg;

    localparam int NW_MAX_DEF = 60;
    localparam int KEY_W_DEF  = 256;

    typedef enum logic [1:0] {
        KEY_128     = 2'b00,
        KEY_192     = 2'b01,
        KEY_256     = 2'b10,
        KEY_256_ALT = 2'b11
    } key_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_DRAIN  = 2'b10
    } state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (key_mode_e'(mode))
            KEY_128: return NK_128;
            KEY_192: return NK_192;
            default: return NK_256;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (key_mode_e'(mode))
            KEY_128: return NR_128;
            KEY_192: return NR_192;
            default: return NR_256;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

`ifdef DEC_EQ_INV_KEY_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

endpackage

// File: rtl/dec_key_word_step.sv
// Combinational AES key-expansion step: produces w[i] from w[i-1], w[i-Nk] and the
// position of i within the current Nk-word group.
module dec_key_word_step
    import dec_round_key_gen_pkg::*;
(
    input  logic [31:0] i_Prev,
    input  logic [31:0] i_Back,
    input  logic [2:0]  i_ModCnt,
    input  logic        i_Nk8,
    input  logic [7:0]  i_Rcon,
    output logic [31:0] o_Word
);

    // S-box as multiplicative inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            inv = gf_mul(inv, inv);
            if (k != 0) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w_Rot;
    logic [31:0] w_SubIn;
    logic [31:0] w_SubOut;
    logic [31:0] w_Temp;

    assign w_Rot   = {i_Prev[23:0], i_Prev[31:24]};
    assign w_SubIn = (i_ModCnt == 3'd0) ? w_Rot : i_Prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_SubOut[8*g +: 8] = sbox(w_SubIn[8*g +: 8]);
    end

    always_comb begin
        w_Temp = i_Prev;
        if (i_ModCnt == 3'd0)
            w_Temp = w_SubOut ^ {i_Rcon, 24'h000000};
        else if (i_Nk8 && (i_ModCnt == 3'd4))
            w_Temp = w_SubOut;
    end

    assign o_Word = i_Back ^ w_Temp;

endmodule

// File: rtl/dec_round_key_gen.sv
// AES decryption key-schedule generator: expands the key one word per clock, then streams
// round keys Nr..0 over valid/ready. Define DEC_EQ_INV_KEY_EN for equivalent-inverse-cipher keys.
module dec_round_key_gen
    import dec_round_key_gen_pkg::*;
#(
    parameter int NW_MAX = NW_MAX_DEF,
    parameter int KEY_W  = KEY_W_DEF
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [KEY_W-1:0] i_Key,
    input  logic [1:0]       i_Key_Mode,
    input  logic             i_Round_Ready,
    output logic [127:0]     o_Round_Key,
    output logic             o_Round_Valid,
    output logic [3:0]       o_Round_Idx,
    output logic             o_Last,
    output logic             o_Busy
);

    state_e      r_State;
    logic [3:0]  r_Nk;
    logic [3:0]  r_Nr;
    logic [5:0]  r_I;
    logic [5:0]  r_LastIdx;
    logic [2:0]  r_ModCnt;
    logic [7:0]  r_Rcon;
    logic [31:0] r_Buf [NW_MAX];

    logic             w_Accept;
    logic [3:0]       w_StartNk;
    logic [KEY_W-1:0] w_KeyAligned;
    logic [31:0]      w_NewWord;
    logic [3:0]       w_NextRound;
    logic [5:0]       w_NextBase;
    logic [127:0]     w_NextRaw;
    logic [127:0]     w_NextKey;
    logic [127:0]     w_FirstKey;

    assign w_Accept     = i_Start && (r_State == ST_IDLE);
    assign w_StartNk    = nk_of(i_Key_Mode);
    // Left-justify the right-aligned key so w0 always sits in the top word.
    assign w_KeyAligned = i_Key << (32 * (8 - int'(w_StartNk)));

    dec_key_word_step u_step (
        .i_Prev   (r_Buf[r_I - 6'd1]),
        .i_Back   (r_Buf[r_I - {2'b00, r_Nk}]),
        .i_ModCnt (r_ModCnt),
        .i_Nk8    (r_Nk == NK_256),
        .i_Rcon   (r_Rcon),
        .o_Word   (w_NewWord)
    );

    assign w_FirstKey  = {r_Buf[r_I - 6'd3], r_Buf[r_I - 6'd2], r_Buf[r_I - 6'd1], w_NewWord};
    assign w_NextRound = o_Round_Idx - 4'd1;
    assign w_NextBase  = {w_NextRound, 2'b00};
    assign w_NextRaw   = {r_Buf[w_NextBase], r_Buf[w_NextBase + 6'd1],
                          r_Buf[w_NextBase + 6'd2], r_Buf[w_NextBase + 6'd3]};

`ifdef DEC_EQ_INV_KEY_EN
    assign w_NextKey = (w_NextRound != 4'd0) ?
                       {inv_mix_col(w_NextRaw[127:96]), inv_mix_col(w_NextRaw[95:64]),
                        inv_mix_col(w_NextRaw[63:32]),  inv_mix_col(w_NextRaw[31:0])} :
                       w_NextRaw;
`else
    assign w_NextKey = w_NextRaw;
`endif

    always_ff @(posedge i_Clk) begin
        if (w_Accept) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < w_StartNk)
                    r_Buf[6'(j)] <= w_KeyAligned[KEY_W-1-32*j -: 32];
            end
        end else if (r_State == ST_EXPAND) begin
            r_Buf[r_I] <= w_NewWord;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State       <= ST_IDLE;
            r_Nk          <= 4'd0;
            r_Nr          <= 4'd0;
            r_I           <= 6'd0;
            r_LastIdx     <= 6'd0;
            r_ModCnt      <= 3'd0;
            r_Rcon        <= 8'h00;
            o_Round_Key   <= 128'd0;
            o_Round_Valid <= 1'b0;
            o_Round_Idx   <= 4'd0;
            o_Last        <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            case (r_State)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_Nk      <= w_StartNk;
                        r_Nr      <= nr_of(i_Key_Mode);
                        r_LastIdx <= {nr_of(i_Key_Mode), 2'b11};
                        r_I       <= {2'b00, w_StartNk};
                        r_ModCnt  <= 3'd0;
                        r_Rcon    <= 8'h01;
                        o_Busy    <= 1'b1;
                        r_State   <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    r_I <= r_I + 6'd1;
                    if (r_ModCnt == 3'd0) r_Rcon <= xtime(r_Rcon);
                    // Nk=8 wraps naturally: r_Nk[2:0]-1 is 7.
                    r_ModCnt <= (r_ModCnt == r_Nk[2:0] - 3'd1) ? 3'd0 : r_ModCnt + 3'd1;
                    if (r_I == r_LastIdx) begin
                        o_Round_Key   <= w_FirstKey;
                        o_Round_Idx   <= r_Nr;
                        o_Round_Valid <= 1'b1;
                        o_Last        <= 1'b0;
                        r_State       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (o_Round_Valid && i_Round_Ready) begin
                        if (o_Round_Idx == 4'd0) begin
                            o_Round_Key   <= 128'd0;
                            o_Round_Valid <= 1'b0;
                            o_Last        <= 1'b0;
                            o_Busy        <= 1'b0;
                            r_State       <= ST_IDLE;
                        end else begin
                            o_Round_Key <= w_NextKey;
                            o_Round_Idx <= w_NextRound;
                            o_Last      <= (w_NextRound == 4'd0);
                        end
                    end
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_round_key_gen.sv
// Directed testbench for dec_round_key_gen: FIPS-197 key vectors, latency, backpressure,
// ignored Start during drain, and asynchronous reset mid-expansion and mid-drain.
module tb_dec_round_key_gen;

    logic         i_Clk = 1'b0;
    logic         i_Rst;
    logic         i_Start;
    logic [255:0] i_Key;
    logic [1:0]   i_Key_Mode;
    logic         i_Round_Ready;
    logic [127:0] o_Round_Key;
    logic         o_Round_Valid;
    logic [3:0]   o_Round_Idx;
    logic         o_Last;
    logic         o_Busy;

    int nCmp = 0;
    int nMis = 0;
    int cycles;

    logic [127:0] expKey   [0:14];
    logic         expKnown [0:14];

    dec_round_key_gen dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Start       (i_Start),
        .i_Key         (i_Key),
        .i_Key_Mode    (i_Key_Mode),
        .i_Round_Ready (i_Round_Ready),
        .o_Round_Key   (o_Round_Key),
        .o_Round_Valid (o_Round_Valid),
        .o_Round_Idx   (o_Round_Idx),
        .o_Last        (o_Last),
        .o_Busy        (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        nCmp++;
        assert (observed === expected) else begin
            nMis++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 128'(o_Round_Valid), 128'd0);
        checkOutput({tag, "_busy"},  128'(o_Busy),        128'd0);
        checkOutput({tag, "_key"},   o_Round_Key,         128'd0);
        checkOutput({tag, "_idx"},   128'(o_Round_Idx),   128'd0);
        checkOutput({tag, "_last"},  128'(o_Last),        128'd0);
    endtask

    task automatic clearExpected();
        for (int r = 0; r < 15; r++) begin
            expKnown[r] = 1'b0;
            expKey[r]   = 128'd0;
        end
    endtask

    task automatic expectKey(input int r, input logic [127:0] k);
        expKnown[r] = 1'b1;
        expKey[r]   = k;
    endtask

    // Pulses Start at the current sample point and counts edges (the Start edge is 1)
    // until valid is seen.
    task automatic applyStimulus(input logic [255:0] key, input logic [1:0] mode,
                                 output int nCycles);
        i_Key      = key;
        i_Key_Mode = mode;
        i_Start    = 1'b1;
        @(posedge i_Clk); #1;
        i_Start = 1'b0;
        nCycles = 1;
        while (!o_Round_Valid && nCycles < 200) begin
            @(posedge i_Clk); #1;
            nCycles++;
        end
    endtask

    task automatic drainKeys(input int nKeys, input int maxStall, input bit pulseStart);
        for (int k = nKeys - 1; k >= 0; k--) begin
            int stall;
            stall = (maxStall > 0) ? int'($urandom_range(maxStall, 0)) : 0;
            for (int s = 0; s <= stall; s++) begin
                i_Round_Ready = (s == stall);
                if (pulseStart && k == nKeys - 3 && s == 0) i_Start = 1'b1;
                checkOutput($sformatf("valid_r%0d", k), 128'(o_Round_Valid), 128'd1);
                checkOutput($sformatf("idx_r%0d", k),   128'(o_Round_Idx),   128'(k));
                checkOutput($sformatf("last_r%0d", k),  128'(o_Last),        128'(k == 0));
                if (expKnown[k])
                    checkOutput($sformatf("key_r%0d", k), o_Round_Key, expKey[k]);
                @(posedge i_Clk); #1;
                i_Start = 1'b0;
            end
        end
        i_Round_Ready = 1'b0;
        checkOutput("post_drain_valid", 128'(o_Round_Valid), 128'd0);
        checkOutput("post_drain_busy",  128'(o_Busy),        128'd0);
        repeat (2) @(posedge i_Clk);
        #1;
        checkOutput("idle_busy", 128'(o_Busy), 128'd0);
    endtask

    task automatic setAes128A();
        clearExpected();
        expectKey(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        expectKey(9,  128'h549932d1f08557681093ed9cbe2c974e);
        expectKey(1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        expectKey(0,  128'h000102030405060708090a0b0c0d0e0f);
    endtask

    task automatic setAes128B();
        clearExpected();
        expectKey(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expectKey(9,  128'hac7766f319fadc2128d12941575c006e);
        expectKey(2,  128'hf2c295f27a96b9435935807a7359f67f);
        expectKey(1,  128'ha0fafe1788542cb123a339392a6c7605);
        expectKey(0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    endtask

    initial begin
        i_Rst         = 1'b1;
        i_Start       = 1'b0;
        i_Key         = '0;
        i_Key_Mode    = 2'b00;
        i_Round_Ready = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;
        checkIdle("reset");
        i_Rst = 1'b0;
        @(posedge i_Clk); #1;

        // AES-128, ready tied high
        setAes128A();
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f, 2'b00, cycles);
        checkOutput("lat128", 128'(cycles), 128'd41);
        checkOutput("busy128", 128'(o_Busy), 128'd1);
        drainKeys(11, 0, 1'b0);

        // AES-128 second vector, random backpressure and a Start pulse mid-drain
        setAes128B();
        applyStimulus(256'h2b7e151628aed2a6abf7158809cf4f3c, 2'b00, cycles);
        checkOutput("lat128b", 128'(cycles), 128'd41);
        drainKeys(11, 5, 1'b1);

        // AES-192
        clearExpected();
        expectKey(12, 128'ha4970a331a78dc09c418c271e3a41d5d);
        expectKey(1,  128'h10111213141516175846f2f95c43f4fe);
        expectKey(0,  128'h000102030405060708090a0b0c0d0e0f);
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f1011121314151617, 2'b01, cycles);
        checkOutput("lat192", 128'(cycles), 128'd47);
        drainKeys(13, 0, 1'b0);

        // AES-256, mode 10 and mode 11
        clearExpected();
        expectKey(14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        expectKey(1,  128'h101112131415161718191a1b1c1d1e1f);
        expectKey(0,  128'h000102030405060708090a0b0c0d0e0f);
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                      2'b10, cycles);
        checkOutput("lat256", 128'(cycles), 128'd53);
        drainKeys(15, 0, 1'b0);
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                      2'b11, cycles);
        checkOutput("lat256m3", 128'(cycles), 128'd53);
        drainKeys(15, 2, 1'b0);

        // Reset during EXPAND
        i_Key      = 256'h000102030405060708090a0b0c0d0e0f;
        i_Key_Mode = 2'b00;
        i_Start    = 1'b1;
        @(posedge i_Clk); #1;
        i_Start = 1'b0;
        repeat (10) @(posedge i_Clk);
        #1;
        checkOutput("exp_busy", 128'(o_Busy), 128'd1);
        #2 i_Rst = 1'b1;
        #1;
        checkIdle("rst_expand");
        #1 i_Rst = 1'b0;
        @(posedge i_Clk); #1;
        checkIdle("after_rst_expand");

        // Reset during DRAIN
        setAes128B();
        applyStimulus(256'h2b7e151628aed2a6abf7158809cf4f3c, 2'b00, cycles);
        checkOutput("lat_pre_rst", 128'(cycles), 128'd41);
        i_Round_Ready = 1'b1;
        repeat (3) @(posedge i_Clk);
        #1;
        checkOutput("drain_idx7", 128'(o_Round_Idx), 128'd7);
        i_Round_Ready = 1'b0;
        #2 i_Rst = 1'b1;
        #1;
        checkIdle("rst_drain");
        #1 i_Rst = 1'b0;
        @(posedge i_Clk); #1;
        checkIdle("after_rst_drain");

        // Full sequence after reset recovery
        setAes128A();
        applyStimulus(256'h000102030405060708090a0b0c0d0e0f, 2'b00, cycles);
        checkOutput("lat_recover", 128'(cycles), 128'd41);
        drainKeys(11, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule

// File: doc/dec_round_key_gen.md
Name: dec_round_key_gen

Overview:
- Sequential AES key-schedule generator for the decryption datapath.
- Takes a 128/192/256-bit cipher key and expands it one 32-bit word per clock into an internal word buffer.
- Then streams the round keys out in reverse order (round Nr down to 0) over a valid/ready handshake.
- Sits between key load and the decryption round engine, which consumes one round key per round.

Parameters:
- NW_MAX, 60, word-buffer depth (4*(14+1)).
- KEY_W, 256, width of key input bus.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Start  in  1  one-cycle pulse; samples i_Key and i_Key_Mode.
- i_Key  in  256  cipher key, right-aligned: 128-bit in [127:0], 192-bit in [191:0], 256-bit in [255:0]; MSW = w0.
- i_Key_Mode  in  2  00=128 (Nk=4, Nr=10), 01=192 (Nk=6, Nr=12), 10/11=256 (Nk=8, Nr=14).
- i_Round_Ready  in  1  consumer accepts the current round key.
- o_Round_Key  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- o_Round_Valid  out  1  o_Round_Key/o_Round_Idx valid.
- o_Round_Idx  out  4  round index r of the presented key.
- o_Last  out  1  high with the round-0 key.
- o_Busy  out  1  high from the Start-accept edge until the round-0 transfer completes.

Behaviour:
- Clock/reset: single clock i_Clk; i_Rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM goes to IDLE. Buffer contents are don't-care.
- Reset mid-operation aborts immediately; no partial keys are presented afterwards.
- FSM states: IDLE -> EXPAND -> DRAIN -> IDLE.
- IDLE: on i_Start, latch the mode, write i_Key words w0..w(Nk-1), set i=Nk, set rcon=0x01, go to EXPAND.
- i_Start is ignored whenever o_Busy=1.
- EXPAND: one word per cycle.
  - t = w[i-1].
  - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon), where xtime = shift-left 1 and XOR 0x1b on carry.
  - Else if Nk==8 and i mod 8 == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - Track i mod Nk with a counter, not a divider.
  - Ends after writing word 4*(Nr+1)-1, i.e. 40/46/52 cycles for 128/192/256. Then set r=Nr and go to DRAIN.
- DRAIN:
  - o_Round_Valid=1, o_Round_Key = words 4r..4r+3, o_Round_Idx=r, o_Last=(r==0).
  - A transfer occurs when valid && ready: r decrements; after the r==0 transfer, valid and busy drop next cycle and the FSM returns to IDLE.
  - While valid && !ready, key, index and last are held stable.
  - Back-to-back transfers are allowed (one key per cycle with ready tied high).
- Latency: first o_Round_Valid is high on the cycle after the last EXPAND cycle, i.e. 1+E cycles after the Start edge (E=40/46/52).
- Mode 11 behaves exactly as 10.

Optional Feature:
- Macro: DEC_EQ_INV_KEY_EN.
- Defined: keys with 0<r<Nr pass through InvMixColumns on the output path (equivalent inverse cipher, FIPS-197 5.3.5). Keys r=Nr and r=0 are unchanged.
- Undefined: raw round keys are emitted, and no InvMixColumns logic is present.

Decomposition:
- Shared package holds:
  - Mode encodings and the Nk/Nr constants per mode.
  - FSM state encoding.
  - The xtime function.
  - Optionally the InvMixColumns column function.
- One sub-module, dec_key_word_step: combinational next-word logic containing 4 S-box instances, RotWord, Rcon XOR and the Nk==8 mid-SubWord select.
- The top level holds the FSM, word buffer, counters and handshake.

Test Plan:
- 128-bit key 000102030405060708090a0b0c0d0e0f, ready=1 -> Start-to-first-valid = 41 cycles; first key (r=10) = 13111d7fe3944a17f307a78b4d2b30c5; last key (r=0) equals the cipher key with o_Last=1; 11 consecutive transfers.
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c -> r=10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
- 192-bit key 000102...1617, mode 01 -> first valid after 47 cycles, r=12 key a4970a331a78dc09c418c271e3a41d5d, 13 keys total.
- 256-bit key 000102...1e1f, mode 10 and again mode 11 -> r=14 key 24fc79ccbf0979e9371ac23c6d68de36 in both runs, 15 keys.
- Backpressure: random ready with 0-5 stall cycles -> key/index stable during stalls, no key skipped or repeated. Also pulse i_Start during DRAIN -> ignored.
- Assert i_Rst during EXPAND and again during DRAIN -> all outputs 0 asynchronously; a subsequent Start produces the correct sequence.
